demux_1n_reg: RTL and testbench

Parametrised, registered 1-to-N demultiplexer with a valid/ready input handshake. Each accepted input word is routed to one of N output slices. The target slice is chosen directly by a select input, or by an internal scan counter that sweeps the channels. This block succeeds the fixed-width combinational demux trees in the lab set. It drives LED/peripheral banks with clocked, glitch-free outputs.

---
 rtl/demux_1n_reg.sv | 103 ++++++++++
 tb/tb_demux_1n_reg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1n_reg.sv
// Registered 1-to-N demux: an accepted word lands in its slice one cycle later with a one-hot out_valid pulse.
// in_ready is low under rst, en=0 or freeze; the source holds din until it is accepted.
module demux_1n_reg #(
  parameter int N       = 16,
  parameter int W       = 1,
  parameter bit REVERSE = 1'b0,
  parameter bit HOLD    = 1'b0,
  parameter int DWELL   = 1,
  localparam int SELW   = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [SELW-1:0]   sel,
  input  logic [W-1:0]      din,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N*W-1:0]    dout,
  output logic [N-1:0]      out_valid,
  output logic [SELW-1:0]   cur_sel
);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  logic [N*W-1:0]  dout_q, dout_d;
  logic [N-1:0]    out_valid_q, out_valid_d;
  logic [SELW-1:0] cur_sel_q, cur_sel_d;
  logic [7:0]      dwell_q, dwell_d;
  logic            dir_q, dir_d;

  logic            xfer;
  logic [SELW-1:0] tgt;
  logic [SELW-1:0] phys;
  logic [7:0]      dwell_eff;

  always_comb begin
    in_ready    = en & (mode != MODE_FREEZE) & ~rst;
    xfer        = in_valid & in_ready;
    tgt         = (mode == MODE_DIRECT) ? sel : cur_sel_q;
    phys        = REVERSE ? (SELW'(N - 1) - tgt) : tgt;
    // dir_q remembers the last scan direction, so a 01<->10 switch restarts the dwell count
    dwell_eff   = (((mode == MODE_DOWN) ? 1'b1 : 1'b0) != dir_q) ? 8'd0 : dwell_q;

    dout_d      = dout_q;
    out_valid_d = '0;
    cur_sel_d   = cur_sel_q;
    dwell_d     = dwell_q;
    dir_d       = dir_q;

    if (mode != MODE_FREEZE) begin
      if (!HOLD) begin
        dout_d = '0;
      end
      if (xfer) begin
        dout_d[phys*W +: W] = din;
        out_valid_d[phys]   = 1'b1;
      end
      if (en) begin
        if (mode == MODE_DIRECT) begin
          dwell_d = '0;
          if (xfer) begin
            cur_sel_d = sel;
          end
        end else begin
          dir_d   = (mode == MODE_DOWN);
          dwell_d = dwell_eff;
          if (xfer) begin
            if (dwell_eff == 8'(DWELL - 1)) begin
              dwell_d   = '0;
              cur_sel_d = (mode == MODE_DOWN) ? (cur_sel_q - SELW'(1)) : (cur_sel_q + SELW'(1));
            end else begin
              dwell_d = dwell_eff + 8'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q      <= '0;
      out_valid_q <= '0;
      cur_sel_q   <= '0;
      dwell_q     <= '0;
      dir_q       <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      cur_sel_q   <= cur_sel_d;
      dwell_q     <= dwell_d;
      dir_q       <= dir_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign cur_sel   = cur_sel_q;

endmodule

// File: tb/tb_demux_1n_reg.sv
// Two demux_1n_reg instances (plain/clearing/DWELL=2 and reversed/holding/DWELL=1) share one stimulus stream;
// a queue-based scoreboard checks every registered output, plus fixed expectations at the directed scenarios.
module tb_demux_1n_reg;

  logic         clk;
  logic         rst, en, in_valid;
  logic [1:0]   mode;
  logic [3:0]   sel;
  logic [7:0]   din;
  logic         rdy_a, rdy_b;
  logic [127:0] dout_a, dout_b;
  logic [15:0]  ov_a, ov_b;
  logic [3:0]   cur_a, cur_b;

  demux_1n_reg #(.N(16), .W(8), .REVERSE(1'b0), .HOLD(1'b0), .DWELL(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din), .in_valid(in_valid),
    .in_ready(rdy_a), .dout(dout_a), .out_valid(ov_a), .cur_sel(cur_a));

  demux_1n_reg #(.N(16), .W(8), .REVERSE(1'b1), .HOLD(1'b1), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din), .in_valid(in_valid),
    .in_ready(rdy_b), .dout(dout_b), .out_valid(ov_b), .cur_sel(cur_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] dout;
    logic [15:0]  ov;
    logic [3:0]   cur;
  } exp_t;

  exp_t sbq[$];
  int   n_total = 0;
  int   n_pass  = 0;

  logic [127:0] m_dout[2];
  logic [3:0]   m_cur[2];
  int           m_dwell[2];
  bit           m_dir[2];
  bit           p_rev[2]   = '{1'b0, 1'b1};
  bit           p_hold[2]  = '{1'b0, 1'b1};
  int           p_dwell[2] = '{2, 1};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Reference behaviour for instance k, advanced by one clock edge with the current inputs.
  task automatic model(input int k);
    exp_t       e;
    logic [3:0] t, p;
    bit         x, dn;
    e.ov = '0;
    if (rst) begin
      m_dout[k] = '0; m_cur[k] = '0; m_dwell[k] = 0; m_dir[k] = 1'b0;
    end else if (mode != 2'b11) begin
      x = en && in_valid;
      t = (mode == 2'b00) ? sel : m_cur[k];
      p = p_rev[k] ? 4'(15 - t) : t;
      if (!p_hold[k]) m_dout[k] = '0;
      if (x) begin
        m_dout[k][p*8 +: 8] = din;
        e.ov[p] = 1'b1;
      end
      if (en) begin
        if (mode == 2'b00) begin
          m_dwell[k] = 0;
          if (x) m_cur[k] = sel;
        end else begin
          dn = (mode == 2'b10);
          if (dn != m_dir[k]) m_dwell[k] = 0;
          m_dir[k] = dn;
          if (x) begin
            m_dwell[k]++;
            if (m_dwell[k] == p_dwell[k]) begin
              m_dwell[k] = 0;
              m_cur[k] = dn ? 4'(m_cur[k] - 1) : 4'(m_cur[k] + 1);
            end
          end
        end
      end
    end
    e.dout = m_dout[k];
    e.cur  = m_cur[k];
    sbq.push_back(e);
  endtask

  task automatic step(input bit r, input bit e_, input logic [1:0] m, input logic [3:0] s,
                      input logic [7:0] d, input bit v);
    exp_t ea, eb;
    rst = r; en = e_; mode = m; sel = s; din = d; in_valid = v;
    #1;
    check("in_ready_a", rdy_a, !r && e_ && (m != 2'b11));
    check("in_ready_b", rdy_b, !r && e_ && (m != 2'b11));
    model(0);
    model(1);
    @(posedge clk);
    #1;
    ea = sbq.pop_front();
    eb = sbq.pop_front();
    check("sb_dout_a", dout_a, ea.dout);
    check("sb_ov_a",   ov_a,   ea.ov);
    check("sb_cur_a",  cur_a,  ea.cur);
    check("sb_dout_b", dout_b, eb.dout);
    check("sb_ov_b",   ov_b,   eb.ov);
    check("sb_cur_b",  cur_b,  eb.cur);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] x;
    rst = 1'b1; en = 1'b0; mode = 2'b00; sel = '0; din = '0; in_valid = 1'b0;

    // Reset state, then a single direct write and its one-cycle pulse
    step(1, 1, 2'b00, 4'd0, 8'h00, 0);
    check("rst_dout_a", dout_a, '0);
    check("rst_ov_a",   ov_a,   '0);
    check("rst_cur_b",  cur_b,  '0);
    step(0, 1, 2'b00, 4'd5, 8'hA5, 1);
    check("t1_slice5",  dout_a[47:40], 8'hA5);
    check("t1_ov_a",    ov_a, 16'h0020);
    check("t1_dout_a",  dout_a, 128'hA5 << 40);
    check("t1_ov_b",    ov_b, 16'h0400);
    step(0, 1, 2'b00, 4'd5, 8'hA5, 0);
    check("t1_clr_dout", dout_a, '0);
    check("t1_clr_ov",   ov_a, '0);

    // Reversed decode with held slices
    step(1, 1, 2'b00, 4'd0, 8'h00, 0);
    step(0, 1, 2'b00, 4'd0, 8'h11, 1);
    check("t2_ov_b0", ov_b, 16'h8000);
    step(0, 1, 2'b00, 4'd3, 8'h22, 1);
    check("t2_ov_b1", ov_b, 16'h1000);
    step(0, 1, 2'b00, 4'd3, 8'h22, 0);
    x = '0; x[127:120] = 8'h11; x[103:96] = 8'h22;
    check("t2_hold_b", dout_b, x);
    check("t2_ov_idle", ov_b, '0);

    // Scan up across the wrap, then reverse direction
    step(0, 1, 2'b00, 4'd0, 8'h30, 1);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 2'b01, 4'd0, 8'(i), 1);
      if (i == 30) check("t3_cur_a_15", cur_a, 4'd15);
    end
    check("t3_wrap_a", cur_a, 4'd0);
    check("t3_wrap_b", cur_b, 4'd0);
    step(0, 1, 2'b10, 4'd0, 8'h55, 1);
    check("t3_dn_first_a", cur_a, 4'd0);
    check("t3_dn_first_b", cur_b, 4'd15);
    step(0, 1, 2'b10, 4'd0, 8'h56, 1);
    check("t3_dn_ov_a", ov_a, 16'h0001);
    check("t3_dn_wrap_a", cur_a, 4'd15);

    // Freeze holds dout, position and dwell count
    step(0, 1, 2'b01, 4'd0, 8'h66, 1);
    check("t4_pre_cur", cur_a, 4'd15);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 2'b11, 4'd2, 8'hF0, 1);
      check("t4_frz_dout", dout_a, 128'h66 << 120);
      check("t4_frz_ov",   ov_a, '0);
      check("t4_frz_cur",  cur_a, 4'd15);
    end
    step(0, 1, 2'b01, 4'd0, 8'h77, 1);
    check("t4_resume_ov",  ov_a, 16'h8000);
    check("t4_resume_cur", cur_a, 4'd0);

    // Reset in the middle of a scan
    step(0, 1, 2'b00, 4'd9, 8'h99, 1);
    step(0, 1, 2'b01, 4'd0, 8'h00, 0);
    check("t5_pre_cur", cur_b, 4'd9);
    step(1, 1, 2'b01, 4'd3, 8'hAB, 1);
    check("t5_dout_b", dout_b, '0);
    check("t5_ov_b",   ov_b, '0);
    check("t5_cur_b",  cur_b, '0);
    check("t5_cur_a",  cur_a, '0);

    // Disabled block ignores valid; direct target seeds the following scan
    step(0, 0, 2'b00, 4'd7, 8'hE7, 1);
    check("t6_en0_ov", ov_a, '0);
    step(0, 1, 2'b00, 4'd7, 8'hE7, 1);
    check("t6_dir_ov_a", ov_a, 16'h0080);
    check("t6_dir_ov_b", ov_b, 16'h0100);
    step(0, 1, 2'b01, 4'd0, 8'h3C, 1);
    check("t6_scan_ov_a", ov_a, 16'h0080);
    check("t6_scan_ov_b", ov_b, 16'h0100);
    check("t6_scan_data", dout_a[63:56], 8'h3C);

    // Mixed traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
